cameralink_capture_ctl: RTL

CAMERALINK_CAPTURE_CTL -- requirements
Module: cameralink_capture_ctl

---
 rtl/cameralink_pkg.sv | 27 ++
 rtl/cameralink_pix_fifo.sv | 71 +++++++
 rtl/cameralink_capture_ctl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cameralink_pkg.sv
// Shared types and constants for the CameraLink capture controller.
package cameralink_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned DEF_XW = 12;
  localparam int unsigned DEF_YW = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT_FV,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] data;
  } pix_t;

  function automatic logic [PIX_W-1:0] pack_rgb(input logic [7:0] r,
                                                 input logic [7:0] g,
                                                 input logic [7:0] b);
    return {b, g, r};
  endfunction

endpackage

// File: rtl/cameralink_pix_fifo.sv
// Small synchronous FIFO for captured pixels; flush empties it in one cycle.
module cameralink_pix_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when a pop frees a slot the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cameralink_capture_ctl.sv
// Frame capture sequencer: syncs to CameraLink FVV/LVV/VCE, checks geometry,
// and streams pixels through a small buffer to a ready/valid consumer.
module cameralink_capture_ctl
  import cameralink_pkg::*;
#(
  parameter int unsigned XW         = DEF_XW,
  parameter int unsigned YW         = DEF_YW,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             CLOCK,
  input  logic             RESET_n,
  input  logic             start,
  input  logic             abort,
  input  logic [XW-1:0]    cfg_width,
  input  logic [YW-1:0]    cfg_height,
  input  logic [7:0]       cfg_frames,
  input  logic             VCE,
  input  logic             LVV,
  input  logic             FVV,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic             cam_enable,
  output logic             cam_request,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_sof,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done,
  output logic             err_overflow,
  output logic             err_geometry,
  output logic [7:0]       frames_done
);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] cfg_width_q, cfg_width_d;
  logic [YW-1:0] cfg_height_q, cfg_height_d;
  logic [7:0]    cfg_frames_q, cfg_frames_d;
  logic [7:0]    frames_done_q, frames_done_d;
  logic          err_overflow_q, err_overflow_d;
  logic          err_geometry_q, err_geometry_d;
  logic          cam_enable_q, cam_enable_d;
  logic          cam_request_q, cam_request_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fvv_prev_q, lvv_prev_q;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  pix_t          push_word, pop_word;
  logic          line_end, frame_end, fv_rise, pix_acc;

  assign line_end  = lvv_prev_q && !LVV;
  assign frame_end = fvv_prev_q && !FVV;
  assign fv_rise   = FVV && !fvv_prev_q;
  assign pix_acc   = FVV && LVV && VCE;
  assign fifo_pop  = !fifo_empty && pix_ready;

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    cfg_width_d    = cfg_width_q;
    cfg_height_d   = cfg_height_q;
    cfg_frames_d   = cfg_frames_q;
    frames_done_d  = frames_done_q;
    err_overflow_d = err_overflow_q;
    err_geometry_d = err_geometry_q;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;
    push_word.sof  = (x_q == '0) && (y_q == '0);
    push_word.data = pack_rgb(red, green, blue);

    // Abort outranks everything, including a coincident start.
    if (abort) begin
      state_d    = ST_IDLE;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (cfg_frames != 8'd0)) begin
            state_d        = ST_SYNC;
            cfg_width_d    = cfg_width;
            cfg_height_d   = cfg_height;
            cfg_frames_d   = cfg_frames;
            frames_done_d  = 8'd0;
            err_overflow_d = 1'b0;
            err_geometry_d = 1'b0;
            fifo_flush     = 1'b1;
          end
        end
        ST_SYNC: begin
          if (!FVV) state_d = ST_WAIT_FV;
        end
        ST_WAIT_FV: begin
          if (fv_rise) begin
            state_d = ST_CAPTURE;
            x_d     = '0;
            y_d     = '0;
          end
        end
        ST_CAPTURE: begin
          if (pix_acc) begin
            fifo_push = 1'b1;
            if (x_q != '1) x_d = x_q + XW'(1);
          end
          if (line_end) begin
            if (y_q != '1) y_d = y_q + YW'(1);
            if (x_q != cfg_width_q) err_geometry_d = 1'b1;
            x_d = '0;
          end
          if (frame_end) begin
            if (y_d != cfg_height_q) err_geometry_d = 1'b1;
            frames_done_d = frames_done_q + 8'd1;
            state_d = (frames_done_d == cfg_frames_q) ? ST_DONE : ST_WAIT_FV;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (fifo_push && fifo_full && !fifo_pop) err_overflow_d = 1'b1;

    // Status outputs are registered copies of the upcoming state.
    cam_enable_d  = (state_d == ST_SYNC) || (state_d == ST_WAIT_FV) ||
                    (state_d == ST_CAPTURE);
    cam_request_d = (state_d == ST_WAIT_FV) && (state_q != ST_WAIT_FV);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge CLOCK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q        <= ST_IDLE;
      x_q            <= '0;
      y_q            <= '0;
      cfg_width_q    <= '0;
      cfg_height_q   <= '0;
      cfg_frames_q   <= '0;
      frames_done_q  <= '0;
      err_overflow_q <= 1'b0;
      err_geometry_q <= 1'b0;
      cam_enable_q   <= 1'b0;
      cam_request_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fvv_prev_q     <= 1'b0;
      lvv_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cfg_width_q    <= cfg_width_d;
      cfg_height_q   <= cfg_height_d;
      cfg_frames_q   <= cfg_frames_d;
      frames_done_q  <= frames_done_d;
      err_overflow_q <= err_overflow_d;
      err_geometry_q <= err_geometry_d;
      cam_enable_q   <= cam_enable_d;
      cam_request_q  <= cam_request_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      fvv_prev_q     <= FVV;
      lvv_prev_q     <= LVV;
    end
  end

  cameralink_pix_fifo #(
    .WIDTH(PIX_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_pix_fifo (
    .clk  (CLOCK),
    .rst_n(RESET_n),
    .flush(fifo_flush),
    .push (fifo_push),
    .wdata(push_word),
    .pop  (fifo_pop),
    .rdata(pop_word),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign pix_data     = pop_word.data;
  assign pix_sof      = pop_word.sof;
  assign pix_valid    = !fifo_empty;
  assign cam_enable   = cam_enable_q;
  assign cam_request  = cam_request_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_overflow_q;
  assign err_geometry = err_geometry_q;
  assign frames_done  = frames_done_q;

endmodule
